spsram_be_init: RTL and testbench

Single-port synchronous SRAM model with a valid/ready request interface, per-byte write enables, a configurable read pipeline latency and a hardware initialisation sweep after reset. It is the parametrised successor to the basic single-port SRAM. Clients that need byte-masked writes, deeper read timing or known-value contents after reset instantiate it directly, with no external init logic.

---
 rtl/spsram_be_init.sv | 147 ++++++++++++++
 tb/tb_spsram_be_init.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_be_init.sv
// Single-port SRAM with byte enables, RD_LAT-deep read pipeline and a post-reset init sweep.
// Optional per-lane even parity: define SPSRAM_BE_INIT_PARITY_EN.

module spsram_be_init_lane (
  input  logic       init,
  input  logic       wr,
  input  logic       be,
  input  logic [7:0] wbyte,
  input  logic [7:0] ibyte,
  output logic       we,
  output logic [7:0] wb
);
  assign we = init | (wr & be);
  assign wb = init ? ibyte : wbyte;
endmodule

module spsram_be_init #(
  parameter int unsigned     W        = 32,
  parameter int unsigned     N        = 128,
  parameter int unsigned     RD_LAT   = 1,
  parameter logic [W-1:0]    INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [W/8-1:0]       req_be,
  input  logic [$clog2(N)-1:0] req_addr,
  input  logic [W-1:0]         req_wdata,
  output logic                 rsp_valid,
  output logic [W-1:0]         rsp_rdata,
  output logic                 rsp_perr
);
  localparam int unsigned NB     = W / 8;
  localparam int unsigned AW     = $clog2(N);
  localparam int unsigned STAGES = RD_LAT - 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          init_cnt;
  logic [NB-1:0][7:0]     mem [N];
  logic                   acc, rd_acc, in_init, rd_perr;
  logic [AW-1:0]          waddr;
  logic [NB-1:0]          lane_we;
  logic [NB-1:0][7:0]     lane_wb;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][W-1:0] dat_pipe;
  logic [STAGES:0]        perr_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT && init_cnt != LAST) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      INIT: if (init_cnt == LAST) state_nxt = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign in_init = (state == INIT);
  assign acc     = req_valid & req_ready;
  assign rd_acc  = acc & ~req_wen;
  assign waddr   = in_init ? init_cnt : req_addr;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    spsram_be_init_lane u_lane (
      .init  (in_init),
      .wr    (acc & req_wen),
      .be    (req_be[i]),
      .wbyte (req_wdata[8*i +: 8]),
      .ibyte (INIT_VAL[8*i +: 8]),
      .we    (lane_we[i]),
      .wb    (lane_wb[i])
    );
  end

  // Storage is never reset; the init sweep establishes known contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (lane_we[i]) mem[waddr][i] <= lane_wb[i];
  end

`ifdef SPSRAM_BE_INIT_PARITY_EN
  logic [NB-1:0] par_mem [N];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (lane_we[i]) par_mem[waddr][i] <= ^lane_wb[i];
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NB; i++)
      rd_perr = rd_perr | ((^mem[req_addr][i]) ^ par_mem[req_addr][i]);
  end
`else
  assign rd_perr = 1'b0;
`endif

  // Data stages load only behind a valid, so the last stage holds the previous response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      perr_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) begin
        dat_pipe[0]  <= mem[req_addr];
        perr_pipe[0] <= rd_perr;
      end
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          dat_pipe[i]  <= dat_pipe[i-1];
          perr_pipe[i] <= perr_pipe[i-1];
        end
      end
    end
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_rdata = dat_pipe[STAGES];
  assign rsp_perr  = perr_pipe[STAGES];

  a_addr_range: assert property (@(posedge clk) disable iff (rst)
    (req_valid && req_ready) |-> ({1'b0, req_addr} < (AW+1)'(N)));

endmodule

// File: tb/tb_spsram_be_init.sv
// Scoreboard bench for spsram_be_init (RD_LAT=3, non-zero INIT_VAL).
module tb_spsram_be_init;
  localparam int W = 32, N = 128, RD_LAT = 3, AW = 7;
  localparam logic [31:0] IV = 32'hC3A5_0F96;
`ifdef SPSRAM_BE_INIT_PARITY_EN
  localparam logic PERR_ON = 1'b1;
`else
  localparam logic PERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        perr;
    logic [31:0] cyc;
  } exp_t;

  logic          clk = 0, rst = 1;
  logic          init_done, req_ready, req_valid = 0, req_wen = 0;
  logic [3:0]    req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0, rsp_rdata;
  logic          rsp_valid, rsp_perr;

  exp_t        exp_q[$];
  logic [31:0] model [N];
  logic        perr_m [N];
  int          errors = 0, checks = 0;
  logic [31:0] cyc = 0;

  spsram_be_init #(.W(W), .N(N), .RD_LAT(RD_LAT), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Response monitor: pops the scoreboard and checks data, parity flag and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rsp_valid_in_reset: got %b want 0", rsp_valid);
      end
    end else if (rsp_valid !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with no read pending, data=%h", rsp_valid, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.data) begin
          errors++;
          $display("FAIL rsp_data: got %h want %h", rsp_rdata, e.data);
        end
        checks++;
        if (rsp_perr !== e.perr) begin
          errors++;
          $display("FAIL rsp_perr: got %b want %b", rsp_perr, e.perr);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL rsp_latency: arrived after edge %0d want edge %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic model_init;
    for (int i = 0; i < N; i++) begin
      model[i]  = IV;
      perr_m[i] = 1'b0;
    end
  endtask

  // All request tasks start and end at posedge+#1.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1; req_wen = 1; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 4; i++)
      if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 0; req_wen = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    exp_t e;
    req_valid = 1; req_wen = 0; req_addr = a; req_be = '0; req_wdata = '0;
    e.data = model[a];
    e.perr = perr_m[a];
    e.cyc  = cyc + RD_LAT;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses missing", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1; req_valid = 1; req_wen = 1; req_be = 4'hF; req_addr = '0; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({init_done, req_ready, rsp_valid, rsp_perr, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_values: got done=%b rdy=%b vld=%b perr=%b data=%h want all 0",
               init_done, req_ready, rsp_valid, rsp_perr, rsp_rdata);
    end
    @(posedge clk); #1;
    rst = 0;
    model_init();
    wait_init(n);
    req_valid = 0; req_wen = 0;
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL init_cycles: ready low for %0d cycles want %0d", n, N);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got %b want 1", init_done);
    end
    @(posedge clk); #1;
    rd(0); rd(63); rd(127);
    drain();
  endtask

  task automatic test_byte_mask;
    wr(5, 32'hAABBCCDD, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    rd(5);
    wr(5, 32'hFFFFFFFF, 4'h0);
    rd(5);
    wr(6, 32'h0BAD_F00D, 4'b1010);
    rd(6);
    drain();
    checks++;
    if (model[5] !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL mask_model: got %h want aa22cc44", model[5]);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) wr(AW'(20 + i), 32'h1000_0001 * (i + 1), 4'hF);
    for (int i = 0; i < 4; i++) rd(AW'(20 + i));
    rd(23); rd(20);
    drain();
  endtask

  task automatic test_reset_mid;
    int n;
    wr(9, 32'hDEADBEEF, 4'hF);
    rd(9);
    @(posedge clk); #1;
    rst = 1;
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL mid_pending: %0d reads pending want 1", exp_q.size());
    end
    exp_q.delete();
    #1;
    checks++;
    if ({init_done, req_ready, rsp_valid, rsp_perr, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL async_reset: got done=%b rdy=%b vld=%b perr=%b data=%h want all 0",
               init_done, req_ready, rsp_valid, rsp_perr, rsp_rdata);
    end
    repeat (2) @(posedge clk); #1;
    rst = 0;
    model_init();
    wait_init(n);
    checks++;
    if (n != N) begin
      errors++;
      $display("FAIL reinit_cycles: ready low for %0d cycles want %0d", n, N);
    end
    @(posedge clk); #1;
    rd(9); rd(0);
    drain();
  endtask

  task automatic test_parity;
    wr(2, 32'h0000_00FF, 4'hF);
    drain();
    dut.mem[2][0][0] = ~dut.mem[2][0][0];
    model[2][0] = ~model[2][0];
    perr_m[2]   = PERR_ON;
    rd(2); rd(3); rd(2);
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_mask();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
